// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared types and helpers for the commit trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    localparam int c_PCW = 9;

    typedef struct packed {
        logic [c_PCW-1:0] pc;
        logic [c_PCW-1:0] link;
    } trace_entry_t;

    // Minimum bits needed to index n distinct values (1 for n <= 2).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_ring.sv
`default_nettype none
// ============================================================================
// Module      : trace_ring
// Description : DEPTH-entry ring buffer with overwrite-oldest on full.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_ring
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int c_AW = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop_req,
    input  trace_entry_t    i_wr_entry,
    output trace_entry_t    o_rd_entry,
    output logic            o_rd_valid,
    output logic [c_AW:0]   o_level,
    output logic            o_overwrite
);

    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    trace_entry_t      r_mem [DEPTH];
    trace_entry_t      r_rd_entry;
    logic              r_rd_valid;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_level;

    logic w_full;
    logic w_pop;
    logic w_over;

    assign w_full = (r_level == c_FULL);
    assign w_pop  = i_pop_req & (r_level != '0);
    assign w_over = i_push & ~w_pop & w_full;

    // Storage is not reset; its contents are only visible through rd_ptr.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wr_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_entry <= '0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_entry <= r_mem[r_rd_ptr];
            if (i_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            // At full, wr_ptr == rd_ptr, so an overwrite also retires the oldest.
            if (w_pop || w_over) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_pop && !i_push) begin
                r_level <= r_level - (c_AW + 1)'(1);
            end else if (i_push && !w_pop && !w_full) begin
                r_level <= r_level + (c_AW + 1)'(1);
            end
        end
    end

    assign o_rd_entry  = r_rd_entry;
    assign o_rd_valid  = r_rd_valid;
    assign o_level     = r_level;
    assign o_overwrite = w_over;

endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : Retirement trace ring, retired counter and hang watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PCW         = c_PCW,
    parameter int CNTW        = 32,
    parameter int WDOG_CYCLES = 1024,
    localparam int c_LW       = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InstDone,
    input  logic [PCW-1:0]   pco,
    input  logic [PCW-1:0]   link,
    input  logic             freeze,
    input  logic             rd_en,
    input  logic             clr_ovf,
    output logic             rd_valid,
    output logic [PCW-1:0]   rd_pc,
    output logic [PCW-1:0]   rd_link,
    output logic [c_LW-1:0]  level,
    output logic             overflow,
    output logic [CNTW-1:0]  retired,
    output logic             hang
);

    localparam int c_WW = clog2(WDOG_CYCLES + 1);
    localparam logic [c_WW-1:0] c_WDOG_MAX = c_WW'(WDOG_CYCLES);

    trace_entry_t     w_wr_entry;
    trace_entry_t     w_rd_entry;
    logic             w_push;
    logic             w_overwrite;
    logic             r_overflow;
    logic [CNTW-1:0]  r_retired;
    logic [c_WW-1:0]  r_wdog;

    // The struct width is fixed by the package; PCW must equal c_PCW.
    assign w_push          = InstDone & ~freeze;
    assign w_wr_entry.pc   = pco;
    assign w_wr_entry.link = link;

    trace_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop_req   (rd_en),
        .i_wr_entry  (w_wr_entry),
        .o_rd_entry  (w_rd_entry),
        .o_rd_valid  (rd_valid),
        .o_level     (level),
        .o_overwrite (w_overwrite)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_retired  <= '0;
            r_wdog     <= '0;
        end else begin
            if (w_overwrite) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (InstDone) r_retired <= r_retired + CNTW'(1);
            if (InstDone) begin
                r_wdog <= '0;
            end else if (r_wdog != c_WDOG_MAX) begin
                r_wdog <= r_wdog + c_WW'(1);
            end
        end
    end

    assign rd_pc    = w_rd_entry.pc;
    assign rd_link  = w_rd_entry.link;
    assign overflow = r_overflow;
    assign retired  = r_retired;
    assign hang     = (r_wdog == c_WDOG_MAX);

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Directed self-checking bench for commit_trace_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;

    localparam int c_DEPTH = 16;
    localparam int c_PCW   = 9;
    localparam int c_CNTW  = 32;
    localparam int c_WDOG  = 8;
    localparam logic [8:0] c_LMASK = 9'h1FF;

    logic              clk;
    logic              rst;
    logic              InstDone;
    logic [c_PCW-1:0]  pco;
    logic [c_PCW-1:0]  link;
    logic              freeze;
    logic              rd_en;
    logic              clr_ovf;
    logic              rd_valid;
    logic [c_PCW-1:0]  rd_pc;
    logic [c_PCW-1:0]  rd_link;
    logic [4:0]        level;
    logic              overflow;
    logic [c_CNTW-1:0] retired;
    logic              hang;

    int vectors;
    int miscompares;

    commit_trace_buffer #(
        .DEPTH       (c_DEPTH),
        .PCW         (c_PCW),
        .CNTW        (c_CNTW),
        .WDOG_CYCLES (c_WDOG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .InstDone (InstDone),
        .pco      (pco),
        .link     (link),
        .freeze   (freeze),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_pc    (rd_pc),
        .rd_link  (rd_link),
        .level    (level),
        .overflow (overflow),
        .retired  (retired),
        .hang     (hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] pc);
        InstDone = 1'b1;
        pco      = pc;
        link     = pc ^ c_LMASK;
        tick();
        InstDone = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; InstDone = 1'b0; pco = '0; link = '0;
        freeze = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset_level",    32'(level),    32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_pc",    32'(rd_pc),    32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_retired",  retired,       32'd0);
        check("reset_hang",     32'(hang),     32'd0);

        // Watchdog: seven idle cycles quiet, eighth asserts hang.
        for (int i = 0; i < 7; i++) tick();
        check("wdog_7_idle", 32'(hang), 32'd0);
        tick();
        check("wdog_8_idle", 32'(hang), 32'd1);

        // Push/pop ordering; the first push also clears hang.
        push(9'h004);
        check("wdog_cleared", 32'(hang),  32'd0);
        check("push1_level",  32'(level), 32'd1);
        push(9'h008);
        push(9'h00C);
        check("push3_level",   32'(level), 32'd3);
        check("push3_retired", retired,    32'd3);
        rd_en = 1'b1;
        tick();
        check("pop1_valid", 32'(rd_valid), 32'd1);
        check("pop1_pc",    32'(rd_pc),    32'h004);
        check("pop1_link",  32'(rd_link),  32'(9'h004 ^ c_LMASK));
        check("pop1_level", 32'(level),    32'd2);
        tick();
        check("pop2_pc",    32'(rd_pc),    32'h008);
        check("pop2_level", 32'(level),    32'd1);
        tick();
        check("pop3_pc",    32'(rd_pc),    32'h00C);
        check("pop3_level", 32'(level),    32'd0);
        rd_en = 1'b0;
        tick();
        check("pop_done_valid", 32'(rd_valid), 32'd0);
        check("pop_hold_pc",    32'(rd_pc),    32'h00C);

        // Empty read is ignored.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty_valid", 32'(rd_valid), 32'd0);
        check("empty_level", 32'(level),    32'd0);

        // Fill then overflow with the 17th push.
        for (int i = 1; i <= 16; i++) push(9'(i));
        check("full_level",    32'(level),    32'd16);
        check("full_overflow", 32'(overflow), 32'd0);
        push(9'd17);
        check("ovf_level",    32'(level),    32'd16);
        check("ovf_overflow", 32'(overflow), 32'd1);

        // Set beats simultaneous clear; clear alone drops the flag.
        clr_ovf = 1'b1;
        push(9'd18);
        check("set_wins_clr", 32'(overflow), 32'd1);
        tick();
        clr_ovf = 1'b0;
        check("clr_alone", 32'(overflow), 32'd0);

        // Push and pop together at full: oldest (3) returned, no overflow.
        rd_en = 1'b1;
        push(9'd19);
        rd_en = 1'b0;
        check("pp_full_valid",    32'(rd_valid), 32'd1);
        check("pp_full_pc",       32'(rd_pc),    32'd3);
        check("pp_full_level",    32'(level),    32'd16);
        check("pp_full_overflow", 32'(overflow), 32'd0);

        // Freeze: retirements counted but nothing stored.
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) push(9'h100 + 9'(i));
        freeze = 1'b0;
        check("freeze_level",    32'(level),    32'd16);
        check("freeze_retired",  retired,       32'd27);
        check("freeze_overflow", 32'(overflow), 32'd0);

        // Drain: surviving entries are 4..19 in order.
        rd_en = 1'b1;
        for (int i = 4; i <= 19; i++) begin
            tick();
            check("drain_pc",   32'(rd_pc),   32'(i));
            check("drain_link", 32'(rd_link), 32'(9'(i) ^ c_LMASK));
        end
        rd_en = 1'b0;
        check("drain_level", 32'(level), 32'd0);

        // Reset mid-read with five entries stored.
        for (int i = 0; i < 5; i++) push(9'h020 + 9'(i));
        check("pre_rst_level", 32'(level), 32'd5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_en = 1'b0;
        check("rst_level",    32'(level),    32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_retired",  retired,       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
